// File: rtl/omux_arbiter.sv
// Round-robin scheduler for the shared record-buffer byte mux.
// Holds a grant for one full record and paces bytes against a ready/valid sink.
module omux_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned REC_BYTES = 16,
  parameter int unsigned SETTLE    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         sel_o,
  input  logic [8*NREQ-1:0]       data_i,
  output logic [7:0]              out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(NREQ)-1:0] cur_src_o,
  output logic                    busy_o,
  output logic [31:0]             rec_count_o,
  output logic                    abort_o
);

  localparam int unsigned SrcW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(REC_BYTES) + 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CntW-1:0] LastByte   = CntW'(REC_BYTES - 1);
  localparam logic [SetW-1:0] SettleLast = SetW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SrcW-1:0] LastSrc    = SrcW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StXfer,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [SrcW-1:0]   cur_src_q, cur_src_d;
  logic [SrcW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [31:0]       rec_count_q, rec_count_d;
  logic              abort_q, abort_d;

  logic              found;
  logic [SrcW-1:0]   winner;
  int unsigned       cand;
  logic              req_cur;
  logic [SrcW-1:0]   next_src;
  logic [7:0]        byte_sel;

  // Scan starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req_i[cand[SrcW-1:0]]) begin
        found  = 1'b1;
        winner = cand[SrcW-1:0];
      end
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (cur_src_q == SrcW'(k)) begin
        byte_sel = data_i[8*k +: 8];
      end
    end
  end

  assign req_cur  = req_i[cur_src_q];
  assign next_src = (cur_src_q == LastSrc) ? '0 : cur_src_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rec_count_d  = rec_count_q;
    abort_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          cur_src_d    = winner;
          settle_cnt_d = '0;
          byte_cnt_d   = '0;
          state_d      = (SETTLE == 0) ? StXfer : StSettle;
        end
      end
      StSettle: begin
        if (!req_cur) begin
          state_d    = StIdle;
          abort_d    = 1'b1;
          ptr_d      = next_src;
          byte_cnt_d = '0;
        end else if (settle_cnt_q == SettleLast) begin
          state_d = StXfer;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StXfer: begin
        // A dropped request wins over a byte offered in the same cycle.
        if (!req_cur) begin
          state_d    = StIdle;
          abort_d    = 1'b1;
          ptr_d      = next_src;
          byte_cnt_d = '0;
        end else if (out_ready_i) begin
          if (byte_cnt_q == LastByte) begin
            rec_count_d = rec_count_q + 32'd1;
            ptr_d       = next_src;
            byte_cnt_d  = '0;
            state_d     = StGap;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      cur_src_q    <= '0;
      ptr_q        <= '0;
      byte_cnt_q   <= '0;
      settle_cnt_q <= '0;
      rec_count_q  <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      ptr_q        <= ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rec_count_q  <= rec_count_d;
      abort_q      <= abort_d;
    end
  end

  // Select is gated by the live request so an aborting source never shifts a byte.
  always_comb begin
    sel_o = '0;
    if (state_q == StXfer && req_cur && out_ready_i) begin
      sel_o[cur_src_q] = 1'b1;
    end
  end

  assign out_valid_o = (state_q == StXfer);
  assign out_data_o  = (state_q == StXfer) ? byte_sel : 8'h00;
  assign cur_src_o   = cur_src_q;
  assign busy_o      = (state_q != StIdle);
  assign rec_count_o = rec_count_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Directed bench for omux_arbiter: stimulus pushes expected bytes/grants into queues,
// a negedge monitor pops and compares whenever the DUT moves a byte or takes a grant.
module tb_omux_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned REC  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  sel;
  logic [31:0] data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  cur_src;
  logic        busy;
  logic [31:0] rec_count;
  logic        abort;

  omux_arbiter #(
    .NREQ      (NREQ),
    .REC_BYTES (REC),
    .SETTLE    (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .sel_o       (sel),
    .data_i      (data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .cur_src_o   (cur_src),
    .busy_o      (busy),
    .rec_count_o (rec_count),
    .abort_o     (abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sel_cycles = 0;
  int pushed = 0;
  int abort_cnt = 0;
  logic [9:0] exp_q[$];
  logic [1:0] gnt_q[$];
  logic [3:0] idx[NREQ];
  logic       busy_prev = 1'b0;

  // Source model: buffer k shifts out 8'h10*k + n, advancing only when selected.
  always_comb begin
    data = '0;
    for (int k = 0; k < NREQ; k++) begin
      data[8*k +: 8] = 8'(16 * k) + {4'b0000, idx[k]};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) idx[k] = 4'd0;
      busy_prev = 1'b0;
    end else begin
      tests++;
      if ($countones(sel) > 1 || (sel != 4'b0000 && !(out_valid && out_ready))) begin
        fails++;
        $display("FAIL sel_invariant: sel_o=%b out_valid_o=%b out_ready_i=%b, required <=1 bit and only with valid&ready",
                 sel, out_valid, out_ready);
      end
      if (busy && !busy_prev) begin
        tests++;
        if (gnt_q.size() == 0) begin
          fails++;
          $display("FAIL grant: unexpected grant to %0d, required none", cur_src);
        end else begin
          logic [1:0] g;
          g = gnt_q.pop_front();
          if (cur_src !== g) begin
            fails++;
            $display("FAIL grant: got source %0d, required %0d", cur_src, g);
          end
        end
      end
      if (sel != 4'b0000) begin
        sel_cycles++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL byte: extra byte src=%0d data=%02h, required none", cur_src, out_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({cur_src, out_data} !== e || sel !== (4'b0001 << e[9:8])) begin
            fails++;
            $display("FAIL byte: got src=%0d data=%02h sel=%b, required src=%0d data=%02h",
                     cur_src, out_data, sel, e[9:8], e[7:0]);
          end
        end
        idx[cur_src] = idx[cur_src] + 4'd1;
      end
      if (abort) abort_cnt++;
      busy_prev = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input int src, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'(src), 8'(16 * src + i)});
    pushed += n;
  endtask

  task automatic wait_rec(input logic [31:0] target, input int budget);
    int k = 0;
    while (rec_count != target && k < budget) begin
      cyc(1);
      k++;
    end
    chk("rec_count_wait", rec_count, target);
  endtask

  task automatic wait_bytes(input int base, input int n, input int budget);
    int k = 0;
    while (sel_cycles - base < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk("bytes_wait", 32'(sel_cycles - base), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_sel", 32'(sel), 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cur_src", 32'(cur_src), 0);
    chk("reset_rec_count", rec_count, 0);
    chk("reset_abort", 32'(abort), 0);
    cyc(2);
    rst_n = 1'b1;

    // Single source, sink always ready: 1 sample cycle + 2 settle cycles, then 16 bytes.
    gnt_q.push_back(2'd0);
    push_rec(0, 16);
    req = 4'b0001;
    cyc(1);
    chk("single_busy", 32'(busy), 1);
    chk("single_settle1_sel", 32'(sel), 0);
    cyc(1);
    chk("single_settle2_valid", 32'(out_valid), 0);
    cyc(1);
    chk("single_first_sel", 32'(sel), 32'h1);
    chk("single_first_data", 32'(out_data), 32'h00);
    cyc(15);
    chk("single_last_data", 32'(out_data), 32'h0f);
    cyc(1);
    chk("single_gap_sel", 32'(sel), 0);
    chk("single_gap_valid", 32'(out_valid), 0);
    chk("single_gap_busy", 32'(busy), 1);
    chk("single_rec_count", rec_count, 1);
    req = 4'b0000;
    cyc(1);
    chk("single_idle", 32'(busy), 0);
    chk("single_sel_cycles", 32'(sel_cycles), 16);

    // Round-robin with all requesting from a fresh pointer.
    do_reset();
    chk("rr_rec_reset", rec_count, 0);
    for (int r = 0; r < 6; r++) begin
      gnt_q.push_back(2'(r % 4));
      push_rec(r % 4, 16);
    end
    req = 4'b1111;
    wait_rec(6, 200);
    req = 4'b0000;
    cyc(1);
    chk("rr_idle", 32'(busy), 0);
    chk("rr_queue_empty", 32'(exp_q.size()), 0);

    // Backpressure on source 3 with ready pattern 1,0,0,1.
    gnt_q.push_back(2'd3);
    push_rec(3, 16);
    req = 4'b1000;
    base = sel_cycles;
    for (int i = 0; i < 300 && rec_count != 32'd7; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc(1);
    end
    chk("bp_rec_count", rec_count, 7);
    chk("bp_sel_cycles", 32'(sel_cycles - base), 16);
    req = 4'b0000;
    out_ready = 1'b1;
    cyc(1);

    // Abort source 2 after 5 bytes; source 3 waiting takes the next grant.
    gnt_q.push_back(2'd2);
    push_rec(2, 5);
    req = 4'b0100;
    base = sel_cycles;
    wait_bytes(base, 5, 100);
    gnt_q.push_back(2'd3);
    push_rec(3, 16);
    req = 4'b1000;
    #1;
    chk("abort_sel_gated", 32'(sel), 0);
    chk("abort_not_yet", 32'(abort), 0);
    cyc(1);
    chk("abort_pulse", 32'(abort), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rec_count", rec_count, 7);
    cyc(1);
    chk("abort_single_pulse", 32'(abort), 0);
    chk("abort_next_src", 32'(cur_src), 3);
    wait_rec(8, 100);
    req = 4'b0000;
    cyc(1);
    chk("abort_count", 32'(abort_cnt), 1);

    // Reset mid-record at byte 7 of source 1.
    gnt_q.push_back(2'd1);
    push_rec(1, 7);
    req = 4'b0010;
    base = sel_cycles;
    wait_bytes(base, 7, 100);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_queue_empty", 32'(exp_q.size()), 0);
    cyc(2);
    req = 4'b0011;
    gnt_q.push_back(2'd0);
    push_rec(0, 16);
    rst_n = 1'b1;
    wait_rec(1, 100);

    // Pointer wrap: record from 2 leaves pointer at 3, then req=1001 grants 3,0,3.
    gnt_q.push_back(2'd2);
    push_rec(2, 16);
    req = 4'b0100;
    wait_rec(2, 100);
    gnt_q.push_back(2'd3);
    push_rec(3, 16);
    gnt_q.push_back(2'd0);
    push_rec(0, 16);
    gnt_q.push_back(2'd3);
    push_rec(3, 16);
    req = 4'b1001;
    wait_rec(5, 200);
    req = 4'b0000;
    cyc(2);
    chk("wrap_idle", 32'(busy), 0);

    chk("final_byte_queue", 32'(exp_q.size()), 0);
    chk("final_grant_queue", 32'(gnt_q.size()), 0);
    chk("final_sel_cycles", 32'(sel_cycles), 32'(pushed));
    chk("final_abort_count", 32'(abort_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
